// File: rtl/vga_pkg.sv
// Shared constants for the VGA text path: arbiter defaults, char_xy/char_code
// widths and a few well-known character codes.
package vga_pkg;

    localparam int NREQ_DEFAULT    = 4;
    localparam int ROM_LAT_DEFAULT = 1;

    localparam int CHAR_XY_W   = 8;
    localparam int CHAR_CODE_W = 7;

    localparam logic [CHAR_CODE_W-1:0] CHAR_NUL   = 7'h00;
    localparam logic [CHAR_CODE_W-1:0] CHAR_SPACE = 7'h20;
    localparam logic [CHAR_CODE_W-1:0] CHAR_ZERO  = 7'h30;
    localparam logic [CHAR_CODE_W-1:0] CHAR_A     = 7'h41;

    // char_xy packs the text row in the upper nibble, the column in the lower.
    function automatic logic [3:0] char_row(input logic [CHAR_XY_W-1:0] xy);
        return xy[7:4];
    endfunction

    function automatic logic [3:0] char_col(input logic [CHAR_XY_W-1:0] xy);
        return xy[3:0];
    endfunction

endpackage

// File: rtl/text_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: scans req starting at ptr, wrapping at N-1,
// and returns the one-hot grant plus the winner index.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] win,
    output logic          any
);

    always_comb begin
        gnt = '0;
        win = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr) + k) % N]) begin
                any = 1'b1;
                win = IW'((int'(ptr) + k) % N);
                gnt[(int'(ptr) + k) % N] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_rom_arbiter.sv
// Round-robin arbiter sharing one character-text ROM among NREQ requesters;
// the winner id rides a pipeline aligned with the ROM latency to route responses.
module text_rom_arbiter
    import vga_pkg::*;
#(
    parameter int NREQ    = NREQ_DEFAULT,
    parameter int ROM_LAT = ROM_LAT_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NREQ-1:0]          req,
    input  logic [CHAR_XY_W*NREQ-1:0] addr,
    output logic [NREQ-1:0]          gnt,
    output logic [CHAR_XY_W-1:0]     rom_addr,
    input  logic [CHAR_CODE_W-1:0]   rom_data,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [CHAR_CODE_W-1:0]   rsp_data
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0]            ptr;
    logic [NREQ-1:0]          pick_gnt;
    logic [IW-1:0]            pick_win;
    logic                     pick_any;
    logic                     grant;
    logic [ROM_LAT:0]         pipe_v;
    logic [ROM_LAT:0][IW-1:0] pipe_id;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .win (pick_win),
        .any (pick_any)
    );

    assign grant = pick_any & en & ~rst;
    assign gnt   = grant ? pick_gnt : '0;

    // Stage 0 lines up with rom_addr; stage ROM_LAT lines up with rom_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            rom_addr  <= '0;
            pipe_v    <= '0;
            pipe_id   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            if (grant) begin
                ptr      <= (pick_win == IW'(NREQ - 1)) ? '0 : pick_win + 1'b1;
                rom_addr <= addr[int'(pick_win)*CHAR_XY_W +: CHAR_XY_W];
            end
            pipe_v[0]  <= grant;
            pipe_id[0] <= pick_win;
            for (int k = 1; k <= ROM_LAT; k++) begin
                pipe_v[k]  <= pipe_v[k-1];
                pipe_id[k] <= pipe_id[k-1];
            end
            rsp_valid <= pipe_v[ROM_LAT] ? (NREQ'(1) << pipe_id[ROM_LAT]) : '0;
            if (pipe_v[ROM_LAT]) begin
                rsp_data <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_text_rom_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_text_rom_arbiter;
    import vga_pkg::*;

    localparam int N   = NREQ_DEFAULT;
    localparam int LAT = ROM_LAT_DEFAULT;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [N-1:0]      req;
    logic [8*N-1:0]    addr;
    logic [N-1:0]      gnt;
    logic [7:0]        rom_addr;
    logic [6:0]        rom_data;
    logic [N-1:0]      rsp_valid;
    logic [6:0]        rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    text_rom_arbiter #(.NREQ(N), .ROM_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .addr      (addr),
        .gnt       (gnt),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    // ROM stand-in: code = low 7 bits of char_xy, LAT registered cycles later.
    logic [6:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr[6:0];
        for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input logic [N-1:0] rq, input logic [8*N-1:0] ad);
        @(posedge clk);
        #1;
        rst  = r;
        en   = e;
        req  = rq;
        addr = ad;
    endtask

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [8*N-1:0] addr_ramp();
        logic [8*N-1:0] a;
        for (int i = 0; i < N; i++) a[8*i +: 8] = 8'(16 * i);
        return a;
    endfunction

    typedef struct {
        int         due;
        int         id;
        logic [6:0] data;
    } rsp_t;

    rsp_t       q[$];
    int         m_ptr = 0;
    logic [7:0] m_rom_addr = 8'h00;
    logic [N-1:0] m_rsp_valid = '0;
    logic [6:0] m_rsp_data = 7'h00;
    int         cyc = 0;
    int         waitc [N];

    // Reference model: checks registered/comb outputs, then advances to the next edge.
    initial begin
        int           w;
        logic [N-1:0] eg;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            w  = (rst || !en) ? -1 : model_pick(req, m_ptr);
            eg = (w >= 0) ? (N'(1) << w) : '0;
            checkOutput("gnt", 32'(gnt), 32'(eg));
            checkOutput("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            checkOutput("rsp_data", 32'(rsp_data), 32'(m_rsp_data));
            for (int i = 0; i < N; i++) begin
                if (rst || !req[i]) waitc[i] = 0;
                else if (en) begin
                    if (w == i) begin
                        checkOutput("starve", 32'(waitc[i] < N), 32'd1);
                        waitc[i] = 0;
                    end else waitc[i]++;
                end
            end
            if (rst) begin
                q.delete();
                m_ptr       = 0;
                m_rom_addr  = 8'h00;
                m_rsp_valid = '0;
                m_rsp_data  = 7'h00;
            end else begin
                m_rsp_valid = '0;
                if (q.size() > 0 && q[0].due == cyc + 1) begin
                    m_rsp_valid = N'(1) << q[0].id;
                    m_rsp_data  = q[0].data;
                    void'(q.pop_front());
                end
                if (w >= 0) begin
                    q.push_back('{cyc + 2 + LAT, w, addr[8*w +: 7]});
                    m_rom_addr = addr[8*w +: 8];
                    m_ptr      = (w + 1) % N;
                end
            end
            cyc++;
        end
    end

    initial begin
        logic [N-1:0]   cur_req;
        logic [8*N-1:0] cur_addr;
        logic [N-1:0]   g;
        rst = 1'b1; en = 1'b0; req = '0; addr = '0;
        applyStimulus(1, 0, '0, '0);
        applyStimulus(1, 0, '0, '0);
        applyStimulus(0, 1, '0, '0);

        // Single request: grant now, rom_addr next cycle, response three cycles on.
        applyStimulus(0, 1, 4'b0001, 32'h0000_0040);
        @(negedge clk) checkOutput("single_gnt", 32'(gnt), 32'h1);
        applyStimulus(0, 1, '0, '0);
        @(negedge clk) checkOutput("single_rom_addr", 32'(rom_addr), 32'h40);
        applyStimulus(0, 1, '0, '0);
        @(negedge clk) checkOutput("single_early", 32'(rsp_valid), 32'h0);
        applyStimulus(0, 1, '0, '0);
        @(negedge clk) begin
            checkOutput("single_rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("single_rsp_data", 32'(rsp_data), 32'h40);
        end

        // Everyone requesting: rotating grants, ramp data back in order.
        applyStimulus(1, 0, '0, '0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, '1, addr_ramp());
            @(negedge clk) begin
                checkOutput("rr_gnt", 32'(gnt), 32'(1 << (k % N)));
                if (k >= 3) begin
                    checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'(1 << ((k - 3) % N)));
                    checkOutput("rr_rsp_data", 32'(rsp_data), 32'(16 * ((k - 3) % N)));
                end
            end
        end
        repeat (4) applyStimulus(0, 1, '0, '0);

        // Requester 1 just won, so 3 goes next, then 1 again.
        applyStimulus(1, 0, '0, '0);
        applyStimulus(0, 1, 4'b0010, 32'h1234_5678);
        @(negedge clk) checkOutput("skip_gnt1", 32'(gnt), 32'h2);
        applyStimulus(0, 1, 4'b1010, 32'h9abc_def0);
        @(negedge clk) checkOutput("skip_gnt3", 32'(gnt), 32'h8);
        applyStimulus(0, 1, 4'b1010, 32'h0f1e_2d3c);
        @(negedge clk) checkOutput("skip_gnt1_again", 32'(gnt), 32'h2);
        repeat (4) applyStimulus(0, 1, '0, '0);

        // Three grants then en low: no new grants, three responses still drain.
        applyStimulus(1, 0, '0, '0);
        repeat (3) applyStimulus(0, 1, '1, addr_ramp());
        for (int j = 0; j < 6; j++) begin
            applyStimulus(0, 0, '1, addr_ramp());
            @(negedge clk) begin
                checkOutput("en_off_gnt", 32'(gnt), 32'h0);
                checkOutput("en_off_rsp", 32'(rsp_valid), (j < 3) ? 32'(1 << j) : 32'h0);
            end
        end

        // Reset with two reads in flight discards them.
        applyStimulus(1, 0, '0, '0);
        repeat (2) applyStimulus(0, 1, '1, addr_ramp());
        applyStimulus(1, 1, '1, addr_ramp());
        @(negedge clk) checkOutput("rst_gnt", 32'(gnt), 32'h0);
        for (int j = 0; j < 5; j++) begin
            applyStimulus(0, 1, '0, '0);
            @(negedge clk) begin
                checkOutput("rst_flush_valid", 32'(rsp_valid), 32'h0);
                checkOutput("rst_flush_data", 32'(rsp_data), 32'h0);
            end
        end
        applyStimulus(0, 1, '1, addr_ramp());
        @(negedge clk) checkOutput("rst_ptr_zero", 32'(gnt), 32'h1);

        // Random traffic; each requester holds req and addr until granted.
        cur_req  = '0;
        cur_addr = '0;
        g        = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(cur_req[i] && !g[i])) begin
                    cur_req[i]          = ($urandom_range(0, 2) != 0);
                    cur_addr[8*i +: 8]  = 8'($urandom);
                end
            end
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), cur_req, cur_addr);
            @(negedge clk) g = gnt;
        end
        repeat (6) applyStimulus(0, 1, '0, '0);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
